// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding, the registered
// output bundle and the per-state output decode.
package reset_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ASSERT   = 3'd0,
        HOLD     = 3'd1,
        WAIT_ACK = 3'd2,
        GAP      = 3'd3,
        RUN      = 3'd4,
        ERROR    = 3'd5
    } state_t;

    typedef struct packed {
        logic rst_core;
        logic rst_periph;
        logic init_req;
        logic ready;
        logic error;
    } outs_t;

    // Every output is a pure function of the state being entered, so the
    // output flops can be loaded from the next-state value on the same edge.
    function automatic outs_t outs_for(input state_t s);
        outs_t o;
        o = '{rst_core: 1'b1, rst_periph: 1'b1, init_req: 1'b0, ready: 1'b0, error: 1'b0};
        case (s)
            WAIT_ACK: begin
                o.rst_core = 1'b0;
                o.init_req = 1'b1;
            end
            GAP:      o.rst_core = 1'b0;
            RUN: begin
                o.rst_core   = 1'b0;
                o.rst_periph = 1'b0;
                o.ready      = 1'b1;
            end
            ERROR:    o.error = 1'b1;
            default:  ;
        endcase
        return o;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake/status bundle between the reset sequencer (master) and the core
// and bench side (slave).
interface reset_sequencer_if;
    import reset_seq_pkg::*;

    logic               soft_reset;
    logic               init_ack;
    logic               rst_core;
    logic               rst_periph;
    logic               init_req;
    logic               ready;
    logic               error;
    logic [STATE_W-1:0] state;

    modport master (
        input  soft_reset, init_ack,
        output rst_core, rst_periph, init_req, ready, error, state
    );

    modport slave (
        output soft_reset, init_ack,
        input  rst_core, rst_periph, init_req, ready, error, state
    );

endinterface

// File: rtl/reset_sync.sv
// Reset synchroniser: asserts immediately with reset, releases on the
// STAGES-th rising clock edge after reset falls.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    output logic rst_sync
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples its neighbour's pre-edge value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Orders per-domain resets: hold core, release core, wait for its init ack,
// then release peripherals; flags a sticky error if the ack never arrives.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    reset_sequencer_if.master    bus
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT) + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic             rst_sync;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    outs_t            outs_q, outs_d;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .rst_sync (rst_sync)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            outs_q  <= outs_for(ASSERT);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            outs_q  <= outs_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;

        // soft_reset outranks ack and timeout; ASSERT only leaves via rst_sync
        if (bus.soft_reset && state_q != ASSERT) begin
            state_d = HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (!rst_sync) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_ACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                WAIT_ACK: begin
                    if (bus.init_ack) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ERROR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RUN, ERROR: ;
                default: begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        outs_d = outs_for(state_d);
    end

    assign bus.rst_core   = outs_q.rst_core;
    assign bus.rst_periph = outs_q.rst_periph;
    assign bus.init_req   = outs_q.init_req;
    assign bus.ready      = outs_q.ready;
    assign bus.error      = outs_q.error;
    assign bus.state      = state_q;

endmodule
